// File: rtl/mr1_mem_responder_if.sv
// mr1_mem_responder_if: split instruction/data request-response bus between the MR1 core and its memory.
interface mr1_mem_responder_if;
  logic        instr_stall;
  logic        data_stall;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wr;
  logic [31:0] data_req_addr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        misalign_err;
  modport slave (
    input  instr_stall, data_stall,
    input  instr_req_valid, instr_req_addr,
    output instr_req_ready, instr_rsp_valid, instr_rsp_data,
    input  data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
    output data_req_ready, data_rsp_valid, data_rsp_data,
    output misalign_err
  );
  modport master (
    output instr_stall, data_stall,
    output instr_req_valid, instr_req_addr,
    input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
    output data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
    input  data_req_ready, data_rsp_valid, data_rsp_data,
    input  misalign_err
  );
endinterface

// File: rtl/mr1_mem_responder.sv
// mr1_mem_responder: word RAM answering MR1 fetches and loads/stores with fixed latency.
// Each port has its own credit-limited response pipeline; the ports never arbitrate.
module mr1_rsp_pipe #(
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_stall,
  input  logic        i_valid,
  input  logic        i_rd,
  input  logic [31:0] i_rdata,
  output logic        o_ready,
  output logic        o_acc,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0]             r_cnt;
  logic [LATENCY-1:0]        r_v;
  logic [LATENCY-1:0][31:0]  r_d;
  logic [LATENCY:0]          w_v;
  logic [LATENCY:0][31:0]    w_d;
  logic                      w_rd_acc;
  assign o_ready     = !i_stall && (r_cnt < CW'(MAX_OUTSTANDING));
  assign o_acc       = i_valid && o_ready;
  assign w_rd_acc    = o_acc && i_rd;
  assign w_v         = {r_v, w_rd_acc};
  assign w_d         = {r_d, i_rdata};
  assign o_rsp_valid = r_v[LATENCY-1];
  assign o_rsp_data  = r_d[LATENCY-1];
  // Data stages load only behind a valid bit, so the last stage holds the previous response.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_v   <= '0;
      r_d   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(w_rd_acc) - CW'(o_rsp_valid);
      r_v   <= w_v[LATENCY-1:0];
      for (int k = 0; k < LATENCY; k++)
        if (w_v[k]) r_d[k] <= w_d[k];
    end
endmodule

module mr1_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic reset_n,
  mr1_mem_responder_if.slave bus
);
  localparam int AW = ADDR_WORDS_LOG2;
  logic [31:0]   r_mem [2**AW];
  logic          r_err;
  logic [AW-1:0] w_iidx;
  logic [AW-1:0] w_didx;
  logic [1:0]    w_lo;
  logic [1:0]    w_sz;
  logic          w_mis;
  logic [3:0]    w_be;
  logic          w_iacc;
  logic          w_dacc;
  logic          w_st;
  logic [31:0]   w_drd;
  logic          w_unused;
  assign w_iidx   = bus.instr_req_addr[AW+1:2];
  assign w_didx   = bus.data_req_addr[AW+1:2];
  assign w_lo     = bus.data_req_addr[1:0];
  assign w_sz     = bus.data_req_size;
  assign w_mis    = (w_sz == 2'd3) || (w_sz == 2'd1 && w_lo[0]) || (w_sz == 2'd2 && w_lo != 2'd0);
  assign w_be     = w_mis ? 4'h0 : w_sz == 2'd0 ? 4'b0001 << w_lo : w_sz == 2'd1 ? (w_lo[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign w_st     = w_dacc && bus.data_req_wr;
  assign w_drd    = w_mis ? 32'h0 : r_mem[w_didx];
  assign w_unused = ^{w_iacc, bus.instr_req_addr[31:AW+2], bus.instr_req_addr[1:0], bus.data_req_addr[31:AW+2]};
  assign bus.misalign_err = r_err;
  mr1_rsp_pipe #(.LATENCY(LATENCY), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ipipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_stall     (bus.instr_stall),
    .i_valid     (bus.instr_req_valid),
    .i_rd        (1'b1),
    .i_rdata     (r_mem[w_iidx]),
    .o_ready     (bus.instr_req_ready),
    .o_acc       (w_iacc),
    .o_rsp_valid (bus.instr_rsp_valid),
    .o_rsp_data  (bus.instr_rsp_data)
  );
  mr1_rsp_pipe #(.LATENCY(LATENCY), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_dpipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_stall     (bus.data_stall),
    .i_valid     (bus.data_req_valid),
    .i_rd        (!bus.data_req_wr),
    .i_rdata     (w_drd),
    .o_ready     (bus.data_req_ready),
    .o_acc       (w_dacc),
    .o_rsp_valid (bus.data_rsp_valid),
    .o_rsp_data  (bus.data_rsp_data)
  );
  // RAM has no reset; reads above sample it before this edge's write lands.
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (w_st && w_be[b]) r_mem[w_didx][8*b +: 8] <= bus.data_req_data[8*b +: 8];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_err <= 1'b0;
    else if (w_dacc && w_mis) r_err <= 1'b1;
endmodule

// File: tb/tb_mr1_mem_responder.sv
// tb_mr1_mem_responder: directed stimulus with queued expectations checked by an independent monitor.
module tb_mr1_mem_responder;
  localparam int LAT = 2;
  localparam logic [31:0] W40 = 32'hDEADBEEF;
  localparam logic [31:0] W80 = 32'hBEEFAA44;
  typedef struct { int c; logic [31:0] d; } exp_t;
  logic clk = 0;
  logic reset_n = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t iq[$];
  exp_t dq[$];
  mr1_mem_responder_if bus();
  mr1_mem_responder #(.ADDR_WORDS_LOG2(12), .LATENCY(LAT), .MAX_OUTSTANDING(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic ireq(input logic [31:0] a, input logic [31:0] exp);
    int n = 0;
    bus.instr_req_valid = 1;
    bus.instr_req_addr  = a;
    do begin @(negedge clk); n++; end while (!bus.instr_req_ready && n < 50);
    chk("ireq_ready", {31'b0, bus.instr_req_ready}, 1);
    if (bus.instr_req_ready) iq.push_back('{cyc + LAT, exp});
    @(posedge clk); #1;
    bus.instr_req_valid = 0;
  endtask
  task automatic dreq(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] exp);
    int n = 0;
    bus.data_req_valid = 1;
    bus.data_req_wr    = wr;
    bus.data_req_addr  = a;
    bus.data_req_size  = sz;
    bus.data_req_data  = wd;
    do begin @(negedge clk); n++; end while (!bus.data_req_ready && n < 50);
    chk("dreq_ready", {31'b0, bus.data_req_ready}, 1);
    if (bus.data_req_ready && !wr) dq.push_back('{cyc + LAT, exp});
    @(posedge clk); #1;
    bus.data_req_valid = 0;
  endtask
  // Fetches with valid held high, alternating 0x40/0x80; checks accept-cycle offsets.
  task automatic iburst(input int n, input int off [6]);
    int got = 0;
    int t0 = 0;
    int waited = 0;
    bus.instr_req_valid = 1;
    bus.instr_req_addr  = 32'h40;
    while (got < n && waited < 100) begin
      @(negedge clk); waited++;
      if (bus.instr_req_ready) begin
        if (got == 0) t0 = cyc;
        chk("burst_accept_offset", cyc - t0, off[got]);
        iq.push_back('{cyc + LAT, bus.instr_req_addr == 32'h40 ? W40 : W80});
        got++;
        @(posedge clk); #1;
        bus.instr_req_addr ^= 32'hC0;
      end
    end
    chk("burst_accept_count", got, n);
    bus.instr_req_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 30) begin @(posedge clk); #2; n++; end
    chk("drain_queues_empty", iq.size() + dq.size(), 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); cyc++; #1;
      if (bus.instr_rsp_valid) begin
        if (iq.size() == 0) begin
          tests++; fails++;
          $display("FAIL instr_unexpected_rsp: got data %h expected no response (cycle %0d)", bus.instr_rsp_data, cyc);
        end else begin
          e = iq.pop_front();
          chk("instr_rsp_cycle", cyc, e.c);
          chk("instr_rsp_data", bus.instr_rsp_data, e.d);
        end
      end else if (iq.size() != 0 && iq[0].c <= cyc) begin
        e = iq.pop_front();
        chk("instr_rsp_missing", 0, 1);
      end
      if (bus.data_rsp_valid) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL data_unexpected_rsp: got data %h expected no response (cycle %0d)", bus.data_rsp_data, cyc);
        end else begin
          e = dq.pop_front();
          chk("data_rsp_cycle", cyc, e.c);
          chk("data_rsp_data", bus.data_rsp_data, e.d);
        end
      end else if (dq.size() != 0 && dq[0].c <= cyc) begin
        e = dq.pop_front();
        chk("data_rsp_missing", 0, 1);
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin : stim
    bus.instr_stall = 0; bus.data_stall = 0;
    bus.instr_req_valid = 0; bus.instr_req_addr = 0;
    bus.data_req_valid = 0; bus.data_req_wr = 0; bus.data_req_addr = 0;
    bus.data_req_size = 0; bus.data_req_data = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1;
    chk("rst_instr_ready", {31'b0, bus.instr_req_ready}, 1);
    chk("rst_data_ready", {31'b0, bus.data_req_ready}, 1);
    chk("rst_instr_rsp_valid", {31'b0, bus.instr_rsp_valid}, 0);
    chk("rst_data_rsp_valid", {31'b0, bus.data_rsp_valid}, 0);
    chk("rst_instr_rsp_data", bus.instr_rsp_data, 0);
    chk("rst_data_rsp_data", bus.data_rsp_data, 0);
    chk("rst_misalign_err", {31'b0, bus.misalign_err}, 0);
    @(posedge clk); #1;
    // Basic fetch latency, then the response word must be held afterwards.
    dreq(1, 32'h40, 2, W40, 0);
    ireq(32'h40, W40);
    drain();
    repeat (3) @(posedge clk); #1;
    chk("instr_rsp_data_held", bus.instr_rsp_data, W40);
    // Byte and half stores merge into the word.
    dreq(1, 32'h80, 2, 32'h11223344, 0);
    dreq(1, 32'h81, 0, 32'h0000AA00, 0);
    dreq(0, 32'h80, 2, 0, 32'h1122AA44);
    dreq(1, 32'h82, 1, 32'hBEEF0000, 0);
    dreq(0, 32'h80, 2, 0, W80);
    drain();
    // Credit throttling with valid held high.
    iburst(6, '{0, 1, 3, 4, 6, 7});
    drain();
    // Same-cycle store and fetch see old data; next-cycle fetch sees new data.
    dreq(1, 32'h100, 2, 32'h0, 0);
    bus.data_req_valid = 1; bus.data_req_wr = 1; bus.data_req_addr = 32'h100;
    bus.data_req_size = 2; bus.data_req_data = 32'h5;
    bus.instr_req_valid = 1; bus.instr_req_addr = 32'h100;
    @(negedge clk);
    chk("same_cycle_readies", {30'b0, bus.instr_req_ready, bus.data_req_ready}, 3);
    iq.push_back('{cyc + LAT, 32'h0});
    @(posedge clk); #1;
    bus.data_req_valid = 0;
    @(negedge clk);
    chk("next_cycle_ready", {31'b0, bus.instr_req_ready}, 1);
    iq.push_back('{cyc + LAT, 32'h5});
    @(posedge clk); #1;
    bus.instr_req_valid = 0;
    drain();
    // Misalignment: sticky flag, zero load data, suppressed store.
    chk("misalign_before", {31'b0, bus.misalign_err}, 0);
    dreq(0, 32'h102, 2, 0, 32'h0);
    chk("misalign_set", {31'b0, bus.misalign_err}, 1);
    dreq(1, 32'h103, 1, 32'hFFFFFFFF, 0);
    dreq(0, 32'h100, 2, 0, 32'h5);
    drain();
    chk("misalign_sticky", {31'b0, bus.misalign_err}, 1);
    // Stall blocks acceptance but the in-flight response still emerges.
    ireq(32'h80, W80);
    bus.instr_stall = 1;
    bus.instr_req_valid = 1;
    bus.data_stall = 1;
    bus.data_req_valid = 1; bus.data_req_wr = 0; bus.data_req_addr = 32'h40; bus.data_req_size = 2;
    repeat (3) begin
      @(negedge clk);
      chk("instr_stall_ready", {31'b0, bus.instr_req_ready}, 0);
      chk("data_stall_ready", {31'b0, bus.data_req_ready}, 0);
    end
    @(posedge clk); #1;
    bus.instr_req_valid = 0; bus.data_req_valid = 0;
    bus.instr_stall = 0; bus.data_stall = 0;
    drain();
    // Reset with one read in flight on each port: both are dropped.
    bus.instr_req_valid = 1; bus.instr_req_addr = 32'h40;
    bus.data_req_valid = 1; bus.data_req_wr = 0; bus.data_req_addr = 32'h80; bus.data_req_size = 2;
    @(negedge clk);
    chk("pre_reset_readies", {30'b0, bus.instr_req_ready, bus.data_req_ready}, 3);
    @(posedge clk); #1;
    bus.instr_req_valid = 0; bus.data_req_valid = 0;
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("reset_instr_rsp_valid", {31'b0, bus.instr_rsp_valid}, 0);
    chk("reset_data_rsp_data", bus.data_rsp_data, 0);
    chk("reset_misalign_cleared", {31'b0, bus.misalign_err}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    #1;
    chk("post_reset_instr_ready", {31'b0, bus.instr_req_ready}, 1);
    chk("post_reset_data_ready", {31'b0, bus.data_req_ready}, 1);
    repeat (6) @(posedge clk); #1;
    iburst(3, '{0, 1, 3, 0, 0, 0});
    dreq(0, 32'h80, 2, 0, W80);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mr1_mem_responder.md
Name: mr1_mem_responder

Overview:
- Memory-side responder for the MR1 split instruction/data request–response buses, at the opposite end from the core.
- Owns a word-organised RAM and answers instruction fetches and data loads/stores with a fixed, parameterised response latency.
- Supports outstanding-request throttling and external stall inputs, so simulation benches and formal harnesses can drive the core against a real memory model.

Parameters:
- ADDR_WORDS_LOG2, 12, RAM depth is 2**ADDR_WORDS_LOG2 32-bit words; word index = addr[ADDR_WORDS_LOG2+1:2]; upper address bits are ignored (aliasing).
- LATENCY, 2, cycles from read acceptance to rsp_valid; legal range 1..8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered reads per port; legal range 1..LATENCY.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_stall  in  1  forces instr_req_ready low.
- data_stall  in  1  forces data_req_ready low.
- instr_req_valid  in  1  fetch request.
- instr_req_ready  out  1  fetch accept.
- instr_req_addr  in  32  fetch byte address.
- instr_rsp_valid  out  1  fetch data valid; there is no ready signal on the response.
- instr_rsp_data  out  32  fetched word.
- data_req_valid  in  1  load/store request.
- data_req_ready  out  1  load/store accept.
- data_req_wr  in  1  1 = store, 0 = load.
- data_req_addr  in  32  byte address.
- data_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- data_req_data  in  32  store data, already placed in its byte lanes.
- data_rsp_valid  out  1  load data valid; no ready.
- data_rsp_data  out  32  full aligned word; the core extracts and extends.
- misalign_err  out  1  sticky error flag.

Behaviour:
- Acceptance: a request is accepted in a cycle when req_valid && req_ready.
- Ready rule: req_ready = !stall && (outstanding_cnt < MAX_OUTSTANDING).
  - Ready is combinational from registered state and the stall input only; it does not depend on req_valid.
  - Stores on the data port still require data_req_ready, but they never increment the outstanding count.
- Read path:
  - An accepted fetch or load samples the RAM word in its acceptance cycle (RAM state before any store in that same cycle).
  - The sampled word enters a LATENCY-deep valid/data shift pipeline.
  - rsp_valid is asserted exactly LATENCY cycles after acceptance, for one cycle.
  - Responses are in order and back-to-back acceptances are allowed, so throughput is 1 per cycle per port when MAX_OUTSTANDING permits.
  - rsp_data is held at its last value when rsp_valid is low.
- Outstanding counter (per port, width clog2(MAX_OUTSTANDING+1)):
  - +1 on an accepted read; -1 on rsp_valid.
  - Both in the same cycle leaves the count unchanged.
  - A response leaving in a cycle does not free a credit in that same cycle.
- Store path:
  - Byte enables: size 0 writes lane addr[1:0]; size 1 writes lanes {2*addr[1], 2*addr[1]+1}; size 2 writes all four lanes.
  - The write commits at the accepting clock edge. A fetch of the same word accepted in the same cycle returns the old data.
  - A fetch accepted in the next cycle returns the new data.
- Misalignment:
  - Conditions: size 1 with addr[0]=1; size 2 with addr[1:0]≠0; size 3.
  - The request is still accepted, and misalign_err sets and stays set until reset.
  - A misaligned store writes nothing.
  - A misaligned load still produces a response, with data 32'h0 and the normal latency.
- Ports are fully independent: fetches and data accesses are accepted and answered in the same cycle without arbitration.
- Reset (asynchronous assert, synchronous release is the caller's responsibility) clears:
  - all pipeline valid bits and the outstanding counters;
  - instr_rsp_valid, data_rsp_valid, rsp_data and misalign_err, all to 0.
  - RAM contents are not reset.
  - In-flight reads at reset are dropped and never answered.
- Stall asserted mid-stream blocks only new acceptances; responses already in the pipeline still emerge on schedule.

Test Plan:
- LATENCY=2: preload word 0x10 = 32'hDEADBEEF, fetch addr 0x40 accepted at cycle t -> instr_rsp_valid=1 with data 32'hDEADBEEF at t+2 only.
- Store word 32'h11223344 at 0x80, then store byte (size 0) 32'h0000AA00 at 0x81, then load 0x80 -> data_rsp_data = 32'h1122AA44.
- MAX_OUTSTANDING=2, LATENCY=2, valid held high -> 2 accepts, ready low for exactly 1 cycle, then 1 accept per response; outstanding never exceeds 2.
- Store to 0x100 and fetch 0x100 in the same cycle (old 32'h0, new 32'h5) -> fetch returns 32'h0; a fetch the next cycle returns 32'h5.
- Load size 2 at 0x102 -> misalign_err=1 from the next cycle, response 32'h0 after LATENCY; a size-1 store at 0x103 leaves RAM unchanged.
- Reset_n pulsed low with 2 reads in flight -> no rsp_valid afterward, counters at 0, ready high on release with stall low.
